// File: rtl/load_store_unit.sv
// Single-port load/store sequencer: turns a decode-stage load or store into one handshaked memory access.
// Latency: request cycle + 1..TIMEOUT_CYC REQ cycles + one DONE cycle; ldata is registered at the ack edge.
// Backpressure: stall holds the pipeline from the request cycle through REQ; a missing ack is bounded by the timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        re_mem,
    input  logic        we_mem,
    input  logic [15:0] addr,
    input  logic [15:0] sdata,
    output logic [15:0] ldata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen in the last REQ cycle an access is allowed to wait for its ack.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;

    // Exactly one of load/store is a legal request; both together is a decode error.
    logic one_req;
    logic both_req;
    logic accept;
    logic ack_hit;
    logic tmo_hit;

    assign one_req  = re_mem ^ we_mem;
    assign both_req = re_mem & we_mem;
    assign accept   = (state == IDLE) && one_req;
    // Ack wins over timeout in the same cycle, so the timeout term requires ack low.
    assign ack_hit  = (state == REQ) && mem_ack;
    assign tmo_hit  = (state == REQ) && !mem_ack && (wait_cnt == WAIT_LAST);

    // Next-state and combinational stall; stall is released in DONE so the pipeline advances there.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (one_req) begin
                    stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (ack_hit || tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_req is a flop that mirrors "currently in REQ", so it has no combinational path from decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= (state_nxt == REQ);
        end
    end

    // Capture the access once at acceptance; the fields hold steady for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
        end else if (accept) begin
            mem_we    <= we_mem;
            mem_addr  <= addr;
            mem_wdata <= sdata;
        end
    end

    // Wait counter: cleared on entry to REQ, counts REQ cycles that pass without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
        end else if ((state == REQ) && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Load result: read data on ack, all-ones poison on timeout; stores never touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldata <= 16'h0000;
        end else if (ack_hit && !mem_we) begin
            ldata <= mem_rdata;
        end else if (tmo_hit && !mem_we) begin
            ldata <= 16'hFFFF;
        end
    end

    // Sticky error: set by a timeout or by a conflicting load+store request, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (tmo_hit || ((state == IDLE) && both_req)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        re_mem;
    logic        we_mem;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [15:0] ldata;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int vectors;
    int miscompares;
    int cyc;

    // Reference state: what ldata and err must be after everything applied so far.
    logic [15:0] m_ldata;
    logic        m_err;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_mem    (re_mem),
        .we_mem    (we_mem),
        .addr      (addr),
        .sdata     (sdata),
        .ldata     (ldata),
        .stall     (stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Runs one access. Entered 1ns after a rising edge with the unit idle; returns 2ns after
    // the edge that starts the DONE cycle. The memory acks in REQ cycle number ack_dly+1.
    // Inputs addr/sdata are scrambled after acceptance to prove the captured copy is held.
    task automatic do_access(input logic st, input logic [15:0] a, input logic [15:0] d,
                             input int ack_dly, input logic [15:0] rd,
                             output int req_n, output int stall_n, output int bad,
                             output int first_c, output int last_c, output logic done_stall);
        logic seen;
        logic fin;
        re_mem = !st; we_mem = st; addr = a; sdata = d; mem_ack = 1'b0;
        req_n = 0; stall_n = 0; bad = 0; first_c = -1; last_c = -1;
        done_stall = 1'b1; seen = 1'b0; fin = 1'b0;
        for (int k = 0; k < 64 && !fin; k++) begin
            #1;
            if (mem_req) begin
                if (!seen) first_c = cyc;
                seen = 1'b1;
                last_c = cyc;
                req_n++;
                if (stall) stall_n++;
                if (mem_we !== st || mem_addr !== a || mem_wdata !== d) bad++;
                mem_ack = (req_n == ack_dly + 1);
                mem_rdata = mem_ack ? rd : 16'($urandom);
            end else if (seen) begin
                // DONE cycle: request inputs are still held high here and must be ignored.
                done_stall = stall;
                fin = 1'b1;
            end else begin
                if (stall) stall_n++;
            end
            if (!fin) begin
                @(posedge clk); #1;
                mem_ack = 1'b0;
                addr = 16'($urandom);
                sdata = 16'($urandom);
            end
        end
        re_mem = 1'b0; we_mem = 1'b0; mem_ack = 1'b0;
        if (!fin) begin
            miscompares++;
            $display("FAIL access_bound: no DONE within 64 cycles, got req_cycles=%0d want a completed access", req_n);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        re_mem = 1'b0; we_mem = 1'b0; mem_ack = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        m_ldata = 16'h0000;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; re_mem = 1'b0; we_mem = 1'b0; mem_ack = 1'b0;
        addr = 16'h0; sdata = 16'h0; mem_rdata = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        // Checked before the first rising edge: the reset must act asynchronously.
        vectors++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want all zero", mem_req, mem_we, mem_addr, mem_wdata);
        end
        vectors++;
        if (ldata !== 16'h0 || err !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got ldata=%h err=%b stall=%b want 0000 0 0", ldata, err, stall);
        end
        next_cycle();
        rst_n = 1'b1;
        m_ldata = 16'h0000;
        m_err = 1'b0;
    endtask

    task automatic test_load();
        int rq, sn, bd, fc, lc;
        logic ds;
        do_access(1'b0, 16'h0040, 16'h5A5A, 1, 16'hBEEF, rq, sn, bd, fc, lc, ds);
        vectors++;
        if (rq !== 2 || sn !== 3) begin
            miscompares++;
            $display("FAIL load_timing: got req_cycles=%0d stall_cycles=%0d want 2 3", rq, sn);
        end
        vectors++;
        if (ldata !== 16'hBEEF || err !== 1'b0 || ds !== 1'b0 || bd !== 0) begin
            miscompares++;
            $display("FAIL load_result: got ldata=%h err=%b done_stall=%b bad_fields=%0d want beef 0 0 0", ldata, err, ds, bd);
        end
        m_ldata = 16'hBEEF;
        next_cycle();
    endtask

    task automatic test_store();
        int rq, sn, bd, fc, lc;
        logic ds;
        do_access(1'b1, 16'h0012, 16'h1234, 0, 16'hDEAD, rq, sn, bd, fc, lc, ds);
        vectors++;
        if (rq !== 1 || sn !== 2 || bd !== 0) begin
            miscompares++;
            $display("FAIL store_req: got req_cycles=%0d stall_cycles=%0d bad_fields=%0d want 1 2 0", rq, sn, bd);
        end
        vectors++;
        if (ldata !== m_ldata || ds !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL store_result: got ldata=%h done_stall=%b err=%b want %h 0 0", ldata, ds, err, m_ldata);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int rq1, sn1, bd1, fc1, lc1, rq2, sn2, bd2, fc2, lc2;
        logic ds1, ds2;
        logic [15:0] l1;
        do_access(1'b0, 16'h0100, 16'h0, 0, 16'h1111, rq1, sn1, bd1, fc1, lc1, ds1);
        l1 = ldata;
        next_cycle();
        do_access(1'b0, 16'h0101, 16'h0, 2, 16'h2222, rq2, sn2, bd2, fc2, lc2, ds2);
        vectors++;
        if (l1 !== 16'h1111 || ldata !== 16'h2222) begin
            miscompares++;
            $display("FAIL b2b_data: got first=%h second=%h want 1111 2222", l1, ldata);
        end
        // Gap between pulses is the DONE cycle plus the idle cycle carrying the new request.
        vectors++;
        if (fc2 - lc1 - 1 !== 2 || rq1 !== 1 || rq2 !== 3) begin
            miscompares++;
            $display("FAIL b2b_gap: got gap=%0d req1=%0d req2=%0d want 2 1 3", fc2 - lc1 - 1, rq1, rq2);
        end
        m_ldata = 16'h2222;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int rq, sn, bd, fc, lc;
        logic ds;
        re_mem = 1'b1; addr = 16'h0777;
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || ldata !== 16'h0 || err !== 1'b0 || mem_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got req=%b ldata=%h err=%b addr=%h want 0 0000 0 0000", mem_req, ldata, err, mem_addr);
        end
        re_mem = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_ldata = 16'h0;
        next_cycle();
        vectors++;
        if (mem_req !== 1'b0 || ldata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_done: got req=%b ldata=%h want 0 0000", mem_req, ldata);
        end
        do_access(1'b0, 16'h0321, 16'h0, 0, 16'hC0DE, rq, sn, bd, fc, lc, ds);
        vectors++;
        if (ldata !== 16'hC0DE || rq !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got ldata=%h req_cycles=%0d err=%b want c0de 1 0", ldata, rq, err);
        end
        m_ldata = 16'hC0DE;
        next_cycle();
    endtask

    task automatic test_both_high();
        int req_seen;
        int stall_seen;
        req_seen = 0; stall_seen = 0;
        re_mem = 1'b1; we_mem = 1'b1; addr = 16'h0999;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (stall) stall_seen++;
            next_cycle();
            if (mem_req) req_seen++;
        end
        re_mem = 1'b0; we_mem = 1'b0;
        vectors++;
        if (req_seen !== 0 || stall_seen !== 0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL both_high: got req_cycles=%0d stall_cycles=%0d err=%b want 0 0 1", req_seen, stall_seen, err);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int rq, sn, bd, fc, lc;
        logic ds;
        // Ack in the last allowed cycle is a normal completion.
        do_access(1'b0, 16'h0050, 16'h0, TO - 1, 16'h7E57, rq, sn, bd, fc, lc, ds);
        vectors++;
        if (rq !== TO || ldata !== 16'h7E57 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_at_limit: got req_cycles=%0d ldata=%h err=%b want %0d 7e57 0", rq, ldata, err, TO);
        end
        next_cycle();
        do_access(1'b0, 16'h0060, 16'h0, 100, 16'h0, rq, sn, bd, fc, lc, ds);
        vectors++;
        if (rq !== TO || ldata !== 16'hFFFF || err !== 1'b1 || ds !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: got req_cycles=%0d ldata=%h err=%b done_stall=%b want %0d ffff 1 0", rq, ldata, err, ds, TO);
        end
        for (int k = 0; k < 10; k++) next_cycle();
        vectors++;
        if (err !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: got err=%b req=%b want 1 0", err, mem_req);
        end
        m_ldata = 16'hFFFF;
        m_err = 1'b1;
    endtask

    task automatic test_random();
        int rq, sn, bd, fc, lc, dly, exp_rq;
        logic ds, st, tmo;
        logic [15:0] a, d, rd;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom);
            a = 16'($urandom);
            d = 16'($urandom);
            rd = 16'($urandom);
            dly = $urandom_range(0, TO + 1);
            tmo = (dly >= TO);
            exp_rq = tmo ? TO : dly + 1;
            if (!st) m_ldata = tmo ? 16'hFFFF : rd;
            if (tmo) m_err = 1'b1;
            do_access(st, a, d, dly, rd, rq, sn, bd, fc, lc, ds);
            vectors++;
            if (rq !== exp_rq || sn !== exp_rq + 1 || bd !== 0 || ds !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_handshake[%0d]: got req=%0d stall=%0d bad=%0d done_stall=%b want %0d %0d 0 0",
                         n, rq, sn, bd, ds, exp_rq, exp_rq + 1);
            end
            vectors++;
            if (ldata !== m_ldata || err !== m_err) begin
                miscompares++;
                $display("FAIL rand_result[%0d]: got ldata=%h err=%b want %h %b", n, ldata, err, m_ldata, m_err);
            end
            next_cycle();
            // Occasionally wiggle ack while idle; it must have no effect.
            if ($urandom_range(0, 2) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = 16'($urandom);
                next_cycle();
                mem_ack = 1'b0;
                vectors++;
                if (ldata !== m_ldata || mem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_ack[%0d]: got ldata=%h req=%b want %h 0", n, ldata, mem_req, m_ldata);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        m_ldata = 16'h0;
        m_err = 1'b0;
        test_reset();
        next_cycle();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_both_high();
        apply_reset();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
